// File: rtl/x_accum_pkg.sv
// Shared types and defaults for the line-scan x-accumulation controller.
// Imported by the controller, its serial divider and the bench.
package x_accum_pkg;

  localparam int LINE_W_D     = 640;
  localparam int X_W_D        = 10;
  localparam int CNT_W_D      = 10;
  localparam int SUM_W_D      = 18;
  localparam int CAL_CYCLES_D = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAL,
    S_SCAN,
    S_DIV,
    S_OUT
  } state_t;

  typedef struct packed {
    logic [X_W_D-1:0]   centroid;
    logic [CNT_W_D-1:0] count;
    logic               none;
  } res_t;

  // Width of a counter that must reach n-1 (at least one bit).
  function automatic int cnt_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/x_accum_ctrl_serial_divider.sv
// Restoring serial divider: one quotient bit per cycle, SUM_W cycles.
// The first bit is produced in the cycle the operands are loaded.
module serial_divider
  import x_accum_pkg::*;
#(
  parameter int SUM_W = SUM_W_D,
  parameter int CNT_W = CNT_W_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic             done,
  output logic [SUM_W-1:0] quotient
);

  localparam int CW = cnt_bits(SUM_W);

  logic [CNT_W-1:0] rem_q;
  logic [CNT_W-1:0] rem_d;
  logic [CNT_W-1:0] dvs_q;
  logic [CNT_W-1:0] r_src;
  logic [CNT_W-1:0] d_src;
  logic [SUM_W-1:0] quo_q;
  logic [SUM_W-1:0] quo_d;
  logic [SUM_W-1:0] q_src;
  logic [CNT_W:0]   trial;
  logic [CNT_W:0]   diff;
  logic             ge;
  logic [CW-1:0]    cnt_q;
  logic             run_q;

  // One restoring step; a fresh start feeds the step from the inputs
  always_comb begin
    r_src = start ? '0 : rem_q;
    q_src = start ? dividend : quo_q;
    d_src = start ? divisor : dvs_q;
    trial = {r_src, q_src[SUM_W-1]};
    ge    = trial >= {1'b0, d_src};
    diff  = trial - {1'b0, d_src};
    rem_d = ge ? CNT_W'(diff) : CNT_W'(trial);
    quo_d = {q_src[SUM_W-2:0], ge};
  end

  // Operand load, iteration counter and running flag
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= divisor;
      cnt_q <= CW'(SUM_W - 1);
      run_q <= 1'b1;
    end else if (run_q) begin
      if (cnt_q != '0) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        cnt_q <= cnt_q - CW'(1);
      end else begin
        run_q <= 1'b0;
      end
    end
  end

  assign done     = run_q && (cnt_q == '0);
  assign quotient = quo_q;

endmodule

// File: rtl/x_accum_ctrl.sv
// Line-scan controller: calibrate, accumulate hit x positions,
// divide for the centroid and hand the result downstream.
module x_accum_ctrl
  import x_accum_pkg::*;
#(
  parameter int LINE_W     = LINE_W_D,
  parameter int X_W        = X_W_D,
  parameter int CNT_W      = CNT_W_D,
  parameter int SUM_W      = SUM_W_D,
  parameter int CAL_CYCLES = CAL_CYCLES_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pix_valid,
  input  logic             pix_hit,
  output logic             thr_mode,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [X_W-1:0]   res_centroid,
  output logic [CNT_W-1:0] res_count,
  output logic             res_none
);

  localparam int CAL_W = cnt_bits(CAL_CYCLES);

  state_t           state_q;
  state_t           state_d;
  logic [X_W-1:0]   x_q;
  logic [SUM_W-1:0] sum_q;
  logic [SUM_W-1:0] sum_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CAL_W-1:0] cal_q;
  logic             cal_done;
  logic             acc;
  logic             last;
  logic             hit_any;
  logic             div_start;
  logic             div_done;
  logic [SUM_W-1:0] quo;
  logic [X_W-1:0]   cent_q;
  logic [CNT_W-1:0] rcnt_q;
  logic             none_q;
  logic             unused_quo;

  // Accept logic and the accumulator values after this pixel
  always_comb begin
    acc      = (state_q == S_SCAN) && pix_valid;
    last     = acc && (x_q == X_W'(LINE_W - 1));
    sum_nxt  = sum_q + (pix_hit ? SUM_W'(x_q) : '0);
    cnt_nxt  = cnt_q + CNT_W'(pix_hit);
    hit_any  = cnt_nxt != '0;
    cal_done = cal_q == CAL_W'(CAL_CYCLES - 1);
  end

  // Divider is loaded with the totals that include the last pixel
  assign div_start = last && hit_any;

  serial_divider #(
    .SUM_W(SUM_W),
    .CNT_W(CNT_W)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .start   (div_start),
    .dividend(sum_nxt),
    .divisor (cnt_nxt),
    .done    (div_done),
    .quotient(quo)
  );

  assign unused_quo = ^quo[SUM_W-1:X_W];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_CAL;
      S_CAL:  if (cal_done) state_d = S_SCAN;
      S_SCAN: if (last) state_d = hit_any ? S_DIV : S_OUT;
      S_DIV:  if (div_done) state_d = S_OUT;
      S_OUT:  if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    thr_mode  = 1'b0;
    busy      = 1'b1;
    res_valid = 1'b0;
    unique case (state_q)
      S_IDLE:  busy = 1'b0;
      S_CAL:   thr_mode = 1'b1;
      S_OUT:   res_valid = 1'b1;
      default: ;
    endcase
  end

  // Calibration count, accumulation and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      cal_q  <= '0;
      x_q    <= '0;
      sum_q  <= '0;
      cnt_q  <= '0;
      cent_q <= '0;
      rcnt_q <= '0;
      none_q <= 1'b0;
    end else begin
      cal_q <= (state_q == S_CAL) ? cal_q + CAL_W'(1) : '0;
      if (state_q == S_IDLE && start) begin
        x_q   <= '0;
        sum_q <= '0;
        cnt_q <= '0;
      end
      if (acc) begin
        x_q   <= last ? '0 : x_q + X_W'(1);
        sum_q <= sum_nxt;
        cnt_q <= cnt_nxt;
      end
      if (last && !hit_any) begin
        cent_q <= '0;
        rcnt_q <= '0;
        none_q <= 1'b1;
      end
      if (state_q == S_DIV && div_done) begin
        cent_q <= quo[X_W-1:0];
        rcnt_q <= cnt_q;
        none_q <= 1'b0;
      end
    end
  end

  assign res_centroid = cent_q;
  assign res_count    = rcnt_q;
  assign res_none     = none_q;

endmodule

// File: tb/tb_x_accum_ctrl.sv
// Bench for x_accum_ctrl: two instances (8-pixel and 640-pixel lines)
// driven with random gaps, hits, stalls and stray starts.
module tb_x_accum_ctrl;
  import x_accum_pkg::*;

  localparam int SW  = 18;
  localparam int BIG = 1 << 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start[2];
  logic       pix_valid[2];
  logic       pix_hit[2];
  logic       res_ready[2];
  logic       thr_mode[2];
  logic       busy[2];
  logic       res_valid[2];
  logic       res_none[2];
  logic [9:0] res_centroid[2];
  logic [9:0] res_count[2];

  int   cyc = 0;
  int   k_start[2];
  int   h_end[2];
  int   v_rise[2];
  res_t exp_res[2];
  bit   chk_en = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  x_accum_ctrl #(.LINE_W(8), .CAL_CYCLES(4)) u_dut8 (
    .clk(clk), .rst(rst), .start(start[0]),
    .pix_valid(pix_valid[0]), .pix_hit(pix_hit[0]),
    .thr_mode(thr_mode[0]), .busy(busy[0]),
    .res_valid(res_valid[0]), .res_ready(res_ready[0]),
    .res_centroid(res_centroid[0]), .res_count(res_count[0]),
    .res_none(res_none[0])
  );

  x_accum_ctrl #(.LINE_W(640), .CAL_CYCLES(3)) u_dut640 (
    .clk(clk), .rst(rst), .start(start[1]),
    .pix_valid(pix_valid[1]), .pix_hit(pix_hit[1]),
    .thr_mode(thr_mode[1]), .busy(busy[1]),
    .res_valid(res_valid[1]), .res_ready(res_ready[1]),
    .res_centroid(res_centroid[1]), .res_count(res_count[1]),
    .res_none(res_none[1])
  );

  function automatic int lw_of(input int d);
    return (d == 0) ? 8 : 640;
  endfunction

  function automatic int cal_of(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  task automatic check(input string nm, input longint got,
                       input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  nm, got, exp, cyc);
  endtask

  task automatic chk_zero(input int d, input string tag);
    check($sformatf("%s_valid%0d", tag, d), res_valid[d], 0);
    check($sformatf("%s_busy%0d", tag, d), busy[d], 0);
    check($sformatf("%s_thr%0d", tag, d), thr_mode[d], 0);
    check($sformatf("%s_none%0d", tag, d), res_none[d], 0);
    check($sformatf("%s_cent%0d", tag, d), res_centroid[d], 0);
    check($sformatf("%s_cnt%0d", tag, d), res_count[d], 0);
  endtask

  // Every cycle: outputs against the windows the driver has predicted
  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int d = 0; d < 2; d++) begin
          bit e_thr, e_busy, e_val;
          e_thr  = cyc > k_start[d] && cyc <= k_start[d] + cal_of(d);
          e_busy = cyc > k_start[d] && cyc <= h_end[d];
          e_val  = cyc >= v_rise[d] && cyc <= h_end[d];
          check($sformatf("thr_mode%0d", d), thr_mode[d], e_thr);
          check($sformatf("busy%0d", d), busy[d], e_busy);
          check($sformatf("res_valid%0d", d), res_valid[d], e_val);
          if (e_val) begin
            check($sformatf("centroid%0d", d), res_centroid[d],
                  exp_res[d].centroid);
            check($sformatf("count%0d", d), res_count[d],
                  exp_res[d].count);
            check($sformatf("none%0d", d), res_none[d],
                  exp_res[d].none);
          end
        end
      end
    end
  endtask

  // abort: 0 none, 1 reset when abort_x pixels taken, 2 reset in divide
  task automatic run_line(input int d, input logic [639:0] hits,
                          input int gap, input int hold, input bit poke,
                          input int abort, input int abort_x,
                          output res_t got, output int lat);
    int n, s, lw, xi, t_last, rise, scan0;
    bit pv;
    lw = lw_of(d);
    n = 0;
    s = 0;
    for (int i = 0; i < lw; i++)
      if (hits[i]) begin
        n++;
        s += i;
      end
    exp_res[d].count    = 10'(n);
    exp_res[d].centroid = (n != 0) ? 10'(s / n) : 10'd0;
    exp_res[d].none     = (n == 0);
    got = '0;
    lat = -1;
    rise = -1;
    t_last = -1;
    @(posedge clk); #1;
    start[d] = 1'b1;
    k_start[d] = cyc;
    h_end[d] = BIG;
    v_rise[d] = BIG;
    scan0 = cyc + cal_of(d) + 1;
    @(posedge clk); #1;
    start[d] = 1'b0;
    xi = 0;
    while (xi < lw) begin
      if (abort == 1 && xi == abort_x && cyc >= scan0) begin
        pix_valid[d] = 1'b0;
        rst = 1'b1;
        h_end[d] = cyc;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_zero(d, "rst_scan");
        return;
      end
      pv = $urandom_range(99) >= gap;
      pix_valid[d] = pv;
      pix_hit[d] = (cyc >= scan0) ? hits[xi] : 1'($urandom_range(1));
      start[d] = poke ? 1'($urandom_range(1)) : 1'b0;
      if (pv && cyc >= scan0) begin
        if (xi == lw - 1) begin
          t_last = cyc;
          v_rise[d] = cyc + 1 + ((n != 0) ? SW : 0);
        end
        xi++;
      end
      @(posedge clk); #1;
    end
    pix_valid[d] = 1'b0;
    pix_hit[d] = 1'b0;
    if (abort == 2) begin
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      h_end[d] = cyc;
      v_rise[d] = BIG;
      @(posedge clk); #1;
      rst = 1'b0;
      start[d] = 1'b0;
      chk_zero(d, "rst_div");
      return;
    end
    while (cyc < v_rise[d]) begin
      if (res_valid[d] && rise < 0) rise = cyc;
      start[d] = poke ? 1'($urandom_range(1)) : 1'b0;
      @(posedge clk); #1;
    end
    if (res_valid[d] && rise < 0) rise = cyc;
    repeat (hold) begin
      start[d] = poke ? 1'($urandom_range(1)) : 1'b0;
      @(posedge clk); #1;
    end
    res_ready[d] = 1'b1;
    start[d] = poke;
    h_end[d] = cyc;
    got.centroid = res_centroid[d];
    got.count = res_count[d];
    got.none = res_none[d];
    @(posedge clk); #1;
    res_ready[d] = 1'b0;
    start[d] = 1'b0;
    lat = (rise < 0) ? -1 : rise - t_last;
  endtask

  initial begin
    logic [639:0] hv;
    res_t got;
    int lat;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0;
      pix_valid[d] = 1'b0;
      pix_hit[d] = 1'b0;
      res_ready[d] = 1'b0;
      k_start[d] = BIG;
      h_end[d] = -1;
      v_rise[d] = BIG;
      exp_res[d] = '0;
    end
    fork
      compare_loop();
    join_none
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) chk_zero(d, "reset");
    chk_en = 1'b1;

    hv = '0;
    hv[2] = 1'b1; hv[3] = 1'b1; hv[4] = 1'b1;
    run_line(0, hv, 0, 0, 1'b0, 0, 0, got, lat);
    check("t1_count", got.count, 3);
    check("t1_cent", got.centroid, 3);
    check("t1_none", got.none, 0);
    check("t1_lat", lat, 19);

    hv = '0;
    hv[0] = 1'b1;
    run_line(0, hv, 30, 1, 1'b0, 0, 0, got, lat);
    check("t2_count", got.count, 1);
    check("t2_cent", got.centroid, 0);
    check("t2_none", got.none, 0);

    hv = '0;
    hv[6] = 1'b1; hv[7] = 1'b1;
    run_line(0, hv, 30, 0, 1'b0, 0, 0, got, lat);
    check("t3_cent", got.centroid, 6);
    check("t3_count", got.count, 2);

    hv = '0;
    run_line(0, hv, 20, 2, 1'b0, 0, 0, got, lat);
    check("t4_none", got.none, 1);
    check("t4_count", got.count, 0);
    check("t4_cent", got.centroid, 0);
    check("t4_lat", lat, 1);

    hv = '0;
    hv[1] = 1'b1; hv[5] = 1'b1;
    run_line(0, hv, 25, 5, 1'b1, 0, 0, got, lat);
    check("t5_cent", got.centroid, 3);

    hv = '0;
    hv[0] = 1'b1; hv[1] = 1'b1; hv[5] = 1'b1;
    run_line(0, hv, 20, 0, 1'b0, 1, 3, got, lat);
    hv = '0;
    hv[3] = 1'b1; hv[7] = 1'b1; hv[6] = 1'b1;
    run_line(0, hv, 20, 1, 1'b0, 0, 0, got, lat);
    check("t6_cent", got.centroid, 5);
    run_line(0, hv, 0, 0, 1'b0, 2, 0, got, lat);
    hv = '0;
    hv[1] = 1'b1; hv[2] = 1'b1; hv[6] = 1'b1;
    run_line(0, hv, 10, 0, 1'b0, 0, 0, got, lat);
    check("t7_cent", got.centroid, 3);

    for (int i = 0; i < 10; i++) begin
      int dens;
      dens = $urandom_range(100);
      hv = '0;
      for (int j = 0; j < 8; j++) hv[j] = $urandom_range(99) < dens;
      run_line(0, hv, $urandom_range(50), $urandom_range(3),
               1'($urandom_range(1)), 0, 0, got, lat);
    end

    hv = '1;
    run_line(1, hv, 30, 2, 1'b1, 0, 0, got, lat);
    check("t8_count", got.count, 640);
    check("t8_cent", got.centroid, 319);
    check("t8_lat", lat, 19);

    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 640; j++) hv[j] = $urandom_range(3) == 0;
      run_line(1, hv, 20, $urandom_range(4), 1'b1, 0, 0, got, lat);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
